// File: rtl/aer_map_arbiter_if.sv
// Handshake bundle between the AER sources, the arbiter and the LRF mapper input.
interface aer_map_arbiter_if #(
  parameter int N_SRC            = 4,
  parameter int MAP_IN_AER_WIDTH = 12
);
  logic [N_SRC-1:0]                            SRC_AERIN_REQ;
  logic [N_SRC-1:0][MAP_IN_AER_WIDTH-1:0]      SRC_AERIN_EVENT;
  logic [N_SRC-1:0][MAP_IN_AER_WIDTH-3:0]      SRC_AERIN_IDX;
  logic [N_SRC-1:0]                            SRC_AERIN_ACK;
  logic                                        MAP_IN_AERIN_REQ;
  logic [MAP_IN_AER_WIDTH-1:0]                 MAP_IN_AERIN_EVENT;
  logic [MAP_IN_AER_WIDTH-3:0]                 MAP_IN_AERIN_IDX;
  logic                                        MAP_IN_AERIN_ACK;

  // Environment side: sources and mapper
  modport master (
    output SRC_AERIN_REQ, SRC_AERIN_EVENT, SRC_AERIN_IDX, MAP_IN_AERIN_ACK,
    input  SRC_AERIN_ACK, MAP_IN_AERIN_REQ, MAP_IN_AERIN_EVENT, MAP_IN_AERIN_IDX
  );

  // Arbiter side
  modport slave (
    input  SRC_AERIN_REQ, SRC_AERIN_EVENT, SRC_AERIN_IDX, MAP_IN_AERIN_ACK,
    output SRC_AERIN_ACK, MAP_IN_AERIN_REQ, MAP_IN_AERIN_EVENT, MAP_IN_AERIN_IDX
  );
endinterface

// File: rtl/aer_map_arbiter.sv
// N-to-1 AER arbiter feeding the LRF mapper: control events first, round robin
// among equals, 4-phase handshakes on both sides, sticky timeout and transfer count.
module aer_map_arbiter #(
  parameter int N_SRC            = 4,
  parameter int MAP_IN_AER_WIDTH = 12,
  parameter int TIMEOUT_CYC      = 1024,
  parameter int CNT_W            = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  aer_map_arbiter_if.slave           bus,
  input  logic                       ERR_CLR,
  output logic                       BUSY,
  output logic [$clog2(N_SRC)-1:0]   GRANT_IDX,
  output logic                       ERR_TIMEOUT,
  output logic [CNT_W-1:0]           EVT_CNT
);
  localparam int GW = $clog2(N_SRC);
  localparam int W  = MAP_IN_AER_WIDTH;
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, MAP_REQ, MAP_REL, SRC_ACK} state_t;

  state_t           r_state, w_state_next;
  logic [GW-1:0]    r_grant, w_grant_next, r_rr, w_rr_next, w_win;
  logic [W-1:0]     r_event, w_event_next;
  logic [W-3:0]     r_idx, w_idx_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [TW-1:0]    r_tmo, w_tmo_next;
  logic             r_err, w_err_next;
  logic             r_map_req, r_busy;
  logic [N_SRC-1:0] r_src_ack, w_ctrl, w_elig;
  logic             w_waiting;

  // Sources carrying a non-neuron event type
  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_ctrl
    assign w_ctrl[gi] = bus.SRC_AERIN_REQ[gi] & (bus.SRC_AERIN_EVENT[gi][W-1:W-2] != 2'b00);
  end

  assign w_elig = (|w_ctrl) ? w_ctrl : bus.SRC_AERIN_REQ;

  always_comb begin : p_winner
    int   w_pos;
    logic w_found;
    w_win   = r_rr;
    w_found = 1'b0;
    w_pos   = 0;
    for (int k = 0; k < N_SRC; k++) begin
      w_pos = (int'(r_rr) + k) % N_SRC;
      if (!w_found && w_elig[w_pos]) begin
        w_win   = GW'(w_pos);
        w_found = 1'b1;
      end
    end
  end

  assign w_waiting = (r_state == MAP_REQ) || (r_state == MAP_REL);

  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_grant;
    w_event_next = r_event;
    w_idx_next   = r_idx;
    w_rr_next    = r_rr;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      IDLE: if (|bus.SRC_AERIN_REQ) begin
        w_state_next = MAP_REQ;
        w_grant_next = w_win;
        w_event_next = bus.SRC_AERIN_EVENT[w_win];
        w_idx_next   = bus.SRC_AERIN_IDX[w_win];
      end
      MAP_REQ: if (bus.MAP_IN_AERIN_ACK)  w_state_next = MAP_REL;
      MAP_REL: if (!bus.MAP_IN_AERIN_ACK) w_state_next = SRC_ACK;
      SRC_ACK: if (!bus.SRC_AERIN_REQ[r_grant]) begin
        w_state_next = IDLE;
        w_rr_next    = (r_grant == GW'(N_SRC - 1)) ? '0 : r_grant + 1'b1;
        w_cnt_next   = r_cnt + 1'b1;
      end
      default: w_state_next = IDLE;
    endcase

    // Counter restarts on every entry into a wait state and saturates at the limit
    if ((w_state_next != r_state) &&
        ((w_state_next == MAP_REQ) || (w_state_next == MAP_REL)))
      w_tmo_next = '0;
    else if (w_waiting && (r_tmo != TMO_MAX))
      w_tmo_next = r_tmo + 1'b1;
    else
      w_tmo_next = r_tmo;

    if (w_waiting && (r_tmo == TMO_MAX)) w_err_next = 1'b1;
    else if (ERR_CLR)                    w_err_next = 1'b0;
    else                                 w_err_next = r_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_event   <= '0;
      r_idx     <= '0;
      r_rr      <= '0;
      r_cnt     <= '0;
      r_tmo     <= '0;
      r_err     <= 1'b0;
      r_map_req <= 1'b0;
      r_busy    <= 1'b0;
      r_src_ack <= '0;
    end else begin
      r_state   <= w_state_next;
      r_grant   <= w_grant_next;
      r_event   <= w_event_next;
      r_idx     <= w_idx_next;
      r_rr      <= w_rr_next;
      r_cnt     <= w_cnt_next;
      r_tmo     <= w_tmo_next;
      r_err     <= w_err_next;
      r_map_req <= (w_state_next == MAP_REQ);
      r_busy    <= (w_state_next != IDLE);
      r_src_ack <= (w_state_next == SRC_ACK) ?
                   ({{(N_SRC-1){1'b0}}, 1'b1} << w_grant_next) : '0;
    end
  end

  assign bus.MAP_IN_AERIN_REQ   = r_map_req;
  assign bus.MAP_IN_AERIN_EVENT = r_event;
  assign bus.MAP_IN_AERIN_IDX   = r_idx;
  assign bus.SRC_AERIN_ACK      = r_src_ack;
  assign BUSY                   = r_busy;
  assign GRANT_IDX              = r_grant;
  assign ERR_TIMEOUT            = r_err;
  assign EVT_CNT                = r_cnt;
endmodule

// File: tb/tb_aer_map_arbiter.sv
// Directed bench for aer_map_arbiter: 4 sources, 16-cycle timeout, 4-bit counter.
module tb_aer_map_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ERR_CLR = 1'b0;
  logic       BUSY;
  logic [1:0] GRANT_IDX;
  logic       ERR_TIMEOUT;
  logic [3:0] EVT_CNT;
  logic [3:0] exp_cnt = '0;
  int         total = 0;
  int         bad = 0;

  aer_map_arbiter_if #(.N_SRC(4), .MAP_IN_AER_WIDTH(12)) bus ();

  aer_map_arbiter #(.N_SRC(4), .MAP_IN_AER_WIDTH(12), .TIMEOUT_CYC(16), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .ERR_CLR(ERR_CLR), .BUSY(BUSY),
    .GRANT_IDX(GRANT_IDX), .ERR_TIMEOUT(ERR_TIMEOUT), .EVT_CNT(EVT_CNT)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // sel 0: mapper REQ high, 1: mapper REQ low, 2: any source ACK high
  task automatic wait_cond(input string tag, input int sel, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((sel == 0 && bus.MAP_IN_AERIN_REQ) || (sel == 1 && !bus.MAP_IN_AERIN_REQ) ||
          (sel == 2 && bus.SRC_AERIN_ACK != 4'b0)) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, " wait"}, 32'(ok), 32'd1);
  endtask

  task automatic src_set(input int g, input logic [11:0] ev, input logic [9:0] ix);
    bus.SRC_AERIN_EVENT[g] = ev;
    bus.SRC_AERIN_IDX[g]   = ix;
    bus.SRC_AERIN_REQ[g]   = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic xfer(input string tag, input int g, input logic [11:0] ev, input logic [9:0] ix,
                      input int dly, input bit rereq, input logic [3:0] drop);
    bit ok;
    wait_cond({tag, " req"}, 0, ok);
    if (!ok) return;
    chk({tag, " grant"}, 32'(GRANT_IDX), 32'(g));
    chk({tag, " event"}, 32'(bus.MAP_IN_AERIN_EVENT), 32'(ev));
    chk({tag, " idx"},   32'(bus.MAP_IN_AERIN_IDX), 32'(ix));
    chk({tag, " busy"},  32'(BUSY), 32'd1);
    chk({tag, " noack"}, 32'(bus.SRC_AERIN_ACK), 32'd0);
    bus.SRC_AERIN_EVENT[g] = ~ev;
    bus.SRC_AERIN_IDX[g]   = ~ix;
    repeat (dly) @(negedge clk);
    chk({tag, " hold_ev"},  32'(bus.MAP_IN_AERIN_EVENT), 32'(ev));
    chk({tag, " hold_idx"}, 32'(bus.MAP_IN_AERIN_IDX), 32'(ix));
    bus.MAP_IN_AERIN_ACK = 1'b1;
    wait_cond({tag, " rel"}, 1, ok);
    bus.MAP_IN_AERIN_ACK = 1'b0;
    wait_cond({tag, " sack"}, 2, ok);
    chk({tag, " ack"}, 32'(bus.SRC_AERIN_ACK), 32'd1 << g);
    bus.SRC_AERIN_REQ[g] = 1'b0;
    bus.SRC_AERIN_REQ    = bus.SRC_AERIN_REQ & ~drop;
    @(negedge clk);
    exp_cnt = exp_cnt + 1'b1;
    $display("xfer %s: src=%0d event=0x%03h idx=0x%03h cnt=%0d", tag, g, ev, ix, EVT_CNT);
    chk({tag, " ack_low"}, 32'(bus.SRC_AERIN_ACK), 32'd0);
    chk({tag, " cnt"},     32'(EVT_CNT), 32'(exp_cnt));
    chk({tag, " idle"},    32'(BUSY), 32'd0);
    chk({tag, " gholds"},  32'(GRANT_IDX), 32'(g));
    if (rereq) src_set(g, ev, ix);
  endtask

  initial begin
    bit ok;
    bus.SRC_AERIN_REQ    = '0;
    bus.SRC_AERIN_EVENT  = '0;
    bus.SRC_AERIN_IDX    = '0;
    bus.MAP_IN_AERIN_ACK = 1'b0;
    do_reset();
    chk("rst busy",  32'(BUSY), 32'd0);
    chk("rst req",   32'(bus.MAP_IN_AERIN_REQ), 32'd0);
    chk("rst ack",   32'(bus.SRC_AERIN_ACK), 32'd0);
    chk("rst grant", 32'(GRANT_IDX), 32'd0);
    chk("rst cnt",   32'(EVT_CNT), 32'd0);
    chk("rst err",   32'(ERR_TIMEOUT), 32'd0);

    // Single source
    src_set(1, 12'h005, 10'h005);
    xfer("single", 1, 12'h005, 10'h005, 2, 1'b0, 4'b0);

    // Round robin over four continuously requesting sources
    do_reset();
    for (int g = 0; g < 4; g++) src_set(g, 12'h010 + 12'(g), 10'h020 + 10'(g));
    xfer("rr0", 0, 12'h010, 10'h020, 1, 1'b1, 4'b0);
    xfer("rr1", 1, 12'h011, 10'h021, 1, 1'b1, 4'b0);
    xfer("rr2", 2, 12'h012, 10'h022, 1, 1'b1, 4'b0);
    xfer("rr3", 3, 12'h013, 10'h023, 1, 1'b0, 4'b0);
    xfer("rr4", 0, 12'h010, 10'h020, 1, 1'b0, 4'b0110);
    chk("rr cnt5", 32'(EVT_CNT), 32'd5);

    // Control priority (rr_ptr is 1 here, so plain round robin would pick src2)
    src_set(0, 12'h001, 10'h001);
    src_set(2, 12'h002, 10'h002);
    src_set(3, 12'hC00, 10'h155);
    xfer("prio3", 3, 12'hC00, 10'h155, 1, 1'b0, 4'b0);
    xfer("prio0", 0, 12'h001, 10'h001, 1, 1'b0, 4'b0);
    xfer("prio2", 2, 12'h002, 10'h002, 1, 1'b0, 4'b0);

    // Timeout: mapper silent
    src_set(1, 12'h011, 10'h011);
    wait_cond("tmo req", 0, ok);
    repeat (15) @(negedge clk);
    chk("tmo before", 32'(ERR_TIMEOUT), 32'd0);
    @(negedge clk);
    chk("tmo set",    32'(ERR_TIMEOUT), 32'd1);
    chk("tmo busy",   32'(BUSY), 32'd1);
    chk("tmo mreq",   32'(bus.MAP_IN_AERIN_REQ), 32'd1);
    bus.MAP_IN_AERIN_ACK = 1'b1;
    wait_cond("tmo rel", 1, ok);
    bus.MAP_IN_AERIN_ACK = 1'b0;
    wait_cond("tmo sack", 2, ok);
    chk("tmo ack", 32'(bus.SRC_AERIN_ACK), 32'd2);
    bus.SRC_AERIN_REQ[1] = 1'b0;
    @(negedge clk);
    exp_cnt = exp_cnt + 1'b1;
    $display("xfer tmo: src=1 cnt=%0d err=%0d", EVT_CNT, ERR_TIMEOUT);
    chk("tmo cnt",    32'(EVT_CNT), 32'(exp_cnt));
    chk("tmo sticky", 32'(ERR_TIMEOUT), 32'd1);
    ERR_CLR = 1'b1;
    @(negedge clk);
    ERR_CLR = 1'b0;
    chk("tmo clr", 32'(ERR_TIMEOUT), 32'd0);

    // Reset during SRC_ACK; rr_ptr is 2, so src3 wins first
    src_set(3, 12'h033, 10'h033);
    wait_cond("ra req", 0, ok);
    chk("ra grant", 32'(GRANT_IDX), 32'd3);
    bus.MAP_IN_AERIN_ACK = 1'b1;
    wait_cond("ra rel", 1, ok);
    bus.MAP_IN_AERIN_ACK = 1'b0;
    wait_cond("ra sack", 2, ok);
    chk("ra ack", 32'(bus.SRC_AERIN_ACK), 32'd8);
    src_set(1, 12'h044, 10'h044);
    rst = 1'b1;
    #1;
    $display("async reset: ack=%0h req=%0d busy=%0d", bus.SRC_AERIN_ACK, bus.MAP_IN_AERIN_REQ, BUSY);
    chk("ra ack0",   32'(bus.SRC_AERIN_ACK), 32'd0);
    chk("ra mreq0",  32'(bus.MAP_IN_AERIN_REQ), 32'd0);
    chk("ra busy0",  32'(BUSY), 32'd0);
    chk("ra grant0", 32'(GRANT_IDX), 32'd0);
    chk("ra ev0",    32'(bus.MAP_IN_AERIN_EVENT), 32'd0);
    chk("ra idx0",   32'(bus.MAP_IN_AERIN_IDX), 32'd0);
    chk("ra cnt0",   32'(EVT_CNT), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = '0;
    xfer("ra src1", 1, 12'h044, 10'h044, 1, 1'b0, 4'b0);
    xfer("ra src3", 3, 12'h033, 10'h033, 1, 1'b0, 4'b0);

    // Counter wrap after 17 transfers
    do_reset();
    for (int i = 0; i < 17; i++) begin
      src_set(i % 4, 12'(i + 1), 10'(i * 3));
      xfer("wrap", i % 4, 12'(i + 1), 10'(i * 3), 2, 1'b0, 4'b0);
    end
    chk("wrap cnt1", 32'(EVT_CNT), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
